seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (even, >= 4).
REQ-002 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port start_i, input, 1, request to begin a division.
REQ-005 SHALL have port Dividend_i, input, WIDTH, dividend, sampled only when start is accepted.
REQ-006 SHALL have port Divisor_i, input, WIDTH, divisor, sampled only when start is accepted.
REQ-007 SHALL have port Q_o, output, WIDTH, quotient.
REQ-008 SHALL have port R_o, output, WIDTH, remainder.
REQ-009 SHALL have port busy_o, output, 1, high while a division is in progress.
REQ-010 SHALL have port done_o, output, 1, one-cycle pulse when Q_o/R_o become valid.
REQ-011 SHALL have port div0_o, output, 1, divide-by-zero flag, valid with done_o.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 Start accepted when start_i=1 in IDLE or DONE; start_i in CALC/FIX SHALL be ignored.
REQ-014 On accept: latch operands, clear iteration counter, go to CALC; busy_o=1 from the next cycle.
REQ-015 CALC SHALL run radix-2 restoring division, one quotient bit per cycle, MSB first, exactly WIDTH cycles.
REQ-016 Each step: shift partial remainder left by one, bring in the next dividend bit, trial-subtract divisor over WIDTH+1 bits; non-negative -> keep difference, quotient bit 1; else restore, bit 0.
REQ-017 After CALC SHALL enter FIX (1 cycle, sign correction or pass-through), then DONE.
REQ-018 DONE SHALL last one cycle: done_o=1, busy_o=0; then IDLE unless a new start is accepted.
REQ-019 Latency: done_o asserted exactly WIDTH+2 cycles after the accepting edge.
REQ-020 Q_o, R_o, div0_o SHALL hold their values from DONE until the next DONE or reset.
REQ-021 Divisor zero: skip CALC, go directly to FIX; Q_o = all ones, R_o = dividend, div0_o=1; done_o 2 cycles after accept.
REQ-022 Back-to-back: start_i=1 during DONE SHALL latch new operands with no idle cycle.

Reset
REQ-023 rst_i=1 SHALL force IDLE, Q_o=0, R_o=0, busy_o=0, done_o=0, div0_o=0, counter=0, immediately and asynchronously.
REQ-024 Reset during CALC/FIX SHALL abort the operation; no done_o pulse SHALL follow.

Configuration
REQ-025 Macro SIGNED_DIV_EN defined: operands two's complement; magnitudes divided; quotient truncates toward zero; remainder takes the dividend's sign; sign correction applied in FIX.
REQ-026 SIGNED_DIV_EN defined: most-negative / -1 SHALL yield Q_o = most-negative, R_o = 0, div0_o = 0.
REQ-027 SIGNED_DIV_EN undefined: operands unsigned; FIX is pass-through; no negation logic instantiated.

Structure
REQ-028 Package div_pkg SHALL hold the FSM state enum and the default WIDTH constant.
REQ-029 Trial subtraction SHALL be a sub-module div_addsub (WIDTH+1-bit adder, carry-in 1, inverted operand); it SHALL also provide the negation used in FIX.

Verification (WIDTH=16)
REQ-030 100 / 7 -> Q_o=14, R_o=2, div0_o=0, done_o exactly 18 cycles after accept.
REQ-031 5 / 0 -> Q_o=0xFFFF, R_o=5, div0_o=1, done_o 2 cycles after accept.
REQ-032 3 / 10 -> Q_o=0, R_o=3; 0xFFFF / 1 -> Q_o=0xFFFF, R_o=0.
REQ-033 start_i pulsed mid-CALC with other operands -> ignored, original result delivered; rst_i mid-CALC -> all outputs 0, no done_o.
REQ-034 Back-to-back: 50 / 5 then start in DONE with 9 / 4 -> Q_o=10, R_o=0, then Q_o=2, R_o=1.
REQ-035 SIGNED_DIV_EN: -7 / 2 -> Q_o=0xFFFD, R_o=0xFFFF; 0x8000 / 0xFFFF -> Q_o=0x8000, R_o=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/div_addsub.sv
// Subtractor a - b built as a + ~b + 1; used for trial subtraction and negation.
module div_addsub #(
  parameter int W = 17
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o
);

  assign diff_o = a_i + ~b_i + W'(1);

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle.
// Define SIGNED_DIV_EN for two's-complement operands with sign fix-up in FIX.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] Dividend_i,
  input  logic [WIDTH-1:0] Divisor_i,
  output logic [WIDTH-1:0] Q_o,
  output logic [WIDTH-1:0] R_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             div0_q, div0_d;
  logic             zero_q, zero_d;

  logic             dvs_zero;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   step_a, step_b, step_s;
  logic [WIDTH-1:0] cap_dvd, cap_dvs;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign dvs_zero = (Divisor_i == '0);
  assign trial    = {rem_q, dvd_q[WIDTH-1]};

  div_addsub #(.W(WIDTH + 1)) u_step (
    .a_i    (step_a),
    .b_i    (step_b),
    .diff_o (step_s)
  );

`ifdef SIGNED_DIV_EN
  logic [WIDTH:0] neg_b, neg_s;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;

  // Outside CALC the step adder is free, so it doubles as a negator.
  always_comb begin
    step_a = '0;
    step_b = {1'b0, Dividend_i};
    neg_b  = {1'b0, Divisor_i};
    case (state_q)
      CALC: begin
        step_a = trial;
        step_b = {1'b0, dvs_q};
      end
      FIX: begin
        step_b = {1'b0, dvd_q};
        neg_b  = {1'b0, rem_q};
      end
      default: ;
    endcase
  end

  div_addsub #(.W(WIDTH + 1)) u_neg (
    .a_i    ({(WIDTH + 1){1'b0}}),
    .b_i    (neg_b),
    .diff_o (neg_s)
  );

  // Divide-by-zero keeps the raw dividend because it is returned as the remainder.
  assign cap_dvd = (Dividend_i[WIDTH-1] && !dvs_zero) ? step_s[WIDTH-1:0] : Dividend_i;
  assign cap_dvs = Divisor_i[WIDTH-1] ? neg_s[WIDTH-1:0] : Divisor_i;
  assign quo_fix = qneg_q ? step_s[WIDTH-1:0] : dvd_q;
  assign rem_fix = rneg_q ? neg_s[WIDTH-1:0] : rem_q;

  always_comb begin
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if (start_i && (state_q == IDLE || state_q == DONE)) begin
      qneg_d = !dvs_zero && (Dividend_i[WIDTH-1] ^ Divisor_i[WIDTH-1]);
      rneg_d = !dvs_zero && Dividend_i[WIDTH-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  assign step_a  = trial;
  assign step_b  = {1'b0, dvs_q};
  assign cap_dvd = Dividend_i;
  assign cap_dvs = Divisor_i;
  assign quo_fix = dvd_q;
  assign rem_fix = rem_q;
`endif

  // NOTE: every always_comb output is defaulted first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          state_d = dvs_zero ? FIX : CALC;
          cnt_d   = '0;
          rem_d   = '0;
          dvd_d   = cap_dvd;
          dvs_d   = cap_dvs;
          zero_d  = dvs_zero;
        end
      end
      CALC: begin
        // A set top bit of the difference means the trial went negative: restore.
        rem_d = step_s[WIDTH] ? trial[WIDTH-1:0] : step_s[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~step_s[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        q_d     = zero_q ? '1 : quo_fix;
        r_d     = zero_q ? dvd_q : rem_fix;
        div0_d  = zero_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
      zero_q  <= zero_d;
    end
  end

  assign Q_o    = q_q;
  assign R_o    = r_q;
  assign div0_o = div0_q;
  assign done_o = (state_q == DONE);
  assign busy_o = (state_q == CALC) || (state_q == FIX);

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues expected results, a monitor checks each done_o.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dvd, dvs;
  logic [W-1:0] q, r;
  logic         busy, done, div0;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         d0;
    int           issue;
    int           lat;
  } exp_t;

  exp_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .Dividend_i (dvd),
    .Divisor_i  (dvs),
    .Q_o        (q),
    .R_o        (r),
    .busy_o     (busy),
    .done_o     (done),
    .div0_o     (div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      if (done) begin
        check("done_single_cycle", 32'(done_prev), 0);
        check("busy_low_in_done", 32'(busy), 0);
        check("result_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("quotient", 32'(q), 32'(e.q));
          check("remainder", 32'(r), 32'(e.r));
          check("div0", 32'(div0), 32'(e.d0));
          check("latency", 32'(cyc - e.issue), 32'(e.lat));
        end
      end
      done_prev = done;
    end
  end

  // Called at a negedge; presents start for one cycle and checks busy afterwards.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ed, input bit expect_result);
    exp_t e;
    dvd   = a;
    dvs   = b;
    start = 1'b1;
    if (expect_result) begin
      e.q     = eq;
      e.r     = er;
      e.d0    = ed;
      e.issue = cyc;
      e.lat   = ed ? 2 : W + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    dvd   = W'($urandom);
    dvs   = W'($urandom);
    check("busy_after_accept", 32'(busy), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 32'(sb.size()), 0);
    @(negedge clk);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed);
    issue(a, b, eq, er, ed, 1'b1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst   = 1'b1;
    start = 1'b0;
    dvd   = '0;
    dvs   = '0;
    #1;
    check("reset_q", 32'(q), 0);
    check("reset_r", 32'(r), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_div0", 32'(div0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    run(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
    run(16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
    run(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
    run(16'd1000, 16'd1000, 16'd1, 16'd0, 1'b0);
    run(16'd0, 16'd5, 16'd0, 16'd0, 1'b0);
`ifdef SIGNED_DIV_EN
    run(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0);
    run(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0);
    run(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0);
    run(16'hFFF8, 16'd0, 16'hFFFF, 16'hFFF8, 1'b1);
`else
    run(16'h8000, 16'h00FF, 16'h0080, 16'h0080, 1'b0);
    run(16'hABCD, 16'h0100, 16'h00AB, 16'h00CD, 1'b0);
`endif

    // A start pulse during CALC must not disturb the running division.
    issue(16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    dvd   = 16'd9;
    dvs   = 16'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Back-to-back: second start is presented while the first is in DONE.
    issue(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("b2b_first_done_seen", 32'(seen), 1);
    issue(16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 1'b1);
    drain();

    // Reset mid-CALC aborts: outputs clear and no done follows.
    issue(16'd1234, 16'd3, 16'd0, 16'd0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_q", 32'(q), 0);
    check("abort_r", 32'(r), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_div0", 32'(div0), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("no_done_after_abort", 32'(seen), 0);

    run(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
